cache_fill_ctrl: RTL
====================

Name: cache_fill_ctrl

Overview:
Lookup and line-fill sequencer for the 4-bank, 32-entry-per-bank cache RAM. Holds one tag and valid bit per bank, since the cache is direct-mapped with bank = address[6:5]. Answers requester lookups as hit or miss. On a miss it bursts 32 words from the external SRAM over a req/ack handshake and drives the cache RAM write port, then commits the tag.

Parameters:
data_width, 8, word width of SRAM, cache RAM and requester data
address_depth_bits, 15, byte address width
line_bits, 5, log2 words per line (bank depth)
bank_bits, 2, log2 number of banks; tag width = address_depth_bits - line_bits - bank_bits (8)

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_i  in  1  asynchronous, active-low reset
req_valid_i  in  1  requester lookup request; req_address_i stable while high and req_ready_o low
req_address_i  in  15  requester address
req_ready_o  out  1  combinational hit: request accepted this cycle
rd_address_o  out  15  to cache RAM read address; equals req_address_i
invalidate_i  in  1  one-cycle pulse, clear all valid bits
busy_o  out  1  high in FILL or COMMIT
mem_req_o  out  1  registered SRAM read request
mem_address_o  out  15  registered SRAM word address
mem_ack_i  in  1  SRAM beat accepted; mem_data_i valid this cycle
mem_data_i  in  8  SRAM read data
bank_i_select_o  out  2  cache RAM write bank
bank_enable_o  out  1  cache RAM write enable (one cycle per word)
write_address_o  out  5  cache RAM write word
write_data_o  out  8  cache RAM write data

Behaviour:
- Reset (reset_i low, async): state IDLE, valid[3:0]=0, tags=0, beat=0, inv_pend=0. All registered outputs 0, including mem_req_o, mem_address_o, bank_enable_o, bank_i_select_o, write_address_o and write_data_o.
- Field split: word=addr[4:0], bank=addr[6:5], tag=addr[14:7].
- IDLE: hit = req_valid_i & valid[bank] & tag_r[bank]==tag; req_ready_o=hit.
  - Read data appears on the cache RAM data output on the edge after the accepted cycle (1-cycle latency).
  - On req_valid_i & !hit: latch bank/tag into fill registers, beat=0. Next state FILL. Next cycle mem_req_o=1 and mem_address_o={tag,bank,5'd0}.
- req_ready_o is 0 outside IDLE.
- FILL: mem_req_o held high. Each cycle with mem_ack_i=1:
  - Register write_data_o=mem_data_i, write_address_o=beat, bank_i_select_o=fill bank, bank_enable_o=1 for the following cycle only.
  - beat increments and mem_address_o advances in the same edge, so back-to-back acks give 1 word/cycle.
  - ack with beat==31: mem_req_o drops next cycle, next state COMMIT.
- mem_ack_i while mem_req_o=0 is ignored.
- COMMIT (1 cycle; the final write is on the bus this cycle): tag_r[bank]=fill tag. valid[bank]=!inv_pend and the other banks are cleared if inv_pend; inv_pend=0. Next state IDLE, where the held request then hits.
- Fill overwrites a valid line in place: valid[bank] is cleared on FILL entry so no stale hit can occur.
- invalidate_i: in IDLE clears valid[3:0] next edge. If coincident with a lookup, that lookup's hit is still honoured. In FILL/COMMIT it sets inv_pend.
- busy_o = state!=IDLE.
- Reset asserted mid-fill aborts the burst: mem_req_o falls asynchronously and no partial line is ever marked valid.

Decomposition:
- Shared package: state encoding (IDLE=0, FILL=1, COMMIT=2), field offsets/widths (LINE_BITS, BANK_BITS, TAG_LSB=7), NUM_BANKS=4.
- One natural sub-module: cache_tag_store (4x tag+valid registers, compare port, write port, clear-all). The FSM and beat counter stay in the top.

Test Plan:
- Cold miss: after reset, req 0x1234 (bank 1, tag 0x24) -> req_ready_o=0; 32 acks with data=beat^0xA5 -> 32 writes on bank 1 with addresses 0..31; COMMIT; req_ready_o=1 the cycle after COMMIT; cache RAM data at word 0x14 = 0xB1.
- Hit: repeat 0x1234 then 0x1220 -> req_ready_o=1 same cycle, no mem_req_o.
- Conflict: req 0x12B4 (bank 1, tag 0x25) -> fill; valid[1] low during fill; afterwards 0x1234 misses.
- Stalled SRAM: ack every 3rd cycle -> exactly 32 bank_enable_o pulses; mem_address_o advances only on ack; last address 0x12BF.
- Invalidate during fill: pulse invalidate_i at beat 10 -> after COMMIT all valid=0; held request re-misses and refills.
- Reset at beat 17 -> mem_req_o=0 immediately, state IDLE, prior valid lines gone; next request misses.

Source files
------------

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants and state encoding for the cache lookup/line-fill sequencer.
package cache_fill_ctrl_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_BITS  = 15;
  localparam int LINE_BITS  = 5;
  localparam int BANK_BITS  = 2;
  localparam int TAG_LSB    = LINE_BITS + BANK_BITS;
  localparam int TAG_BITS   = ADDR_BITS - TAG_LSB;
  localparam int NUM_BANKS  = 1 << BANK_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fillState_e;

endpackage

// File: rtl/cache_tag_store.sv
// Per-bank tag and valid registers for the direct-mapped cache.
// Provides one compare port, one tag write port, a single-bank clear and a clear-all.
module cache_tag_store
  import cache_fill_ctrl_pkg::*;
#(
  parameter int bank_bits = BANK_BITS,
  parameter int tag_bits  = TAG_BITS
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [bank_bits-1:0] lookupBank_i,
  input  logic [tag_bits-1:0]  lookupTag_i,
  output logic                 hit_o,
  input  logic                 clearBankEn_i,
  input  logic [bank_bits-1:0] clearBank_i,
  input  logic                 clearAll_i,
  input  logic                 writeEn_i,
  input  logic [bank_bits-1:0] writeBank_i,
  input  logic [tag_bits-1:0]  writeTag_i,
  input  logic                 writeValid_i
);

  localparam int NB = 1 << bank_bits;

  logic [NB-1:0]               valid_q, valid_d;
  logic [NB-1:0][tag_bits-1:0] tag_q, tag_d;

  assign hit_o = valid_q[lookupBank_i] && (tag_q[lookupBank_i] == lookupTag_i);

  // Clears are applied before the write so a commit can still mark its own line valid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (clearAll_i) begin
      valid_d = '0;
    end
    if (clearBankEn_i) begin
      valid_d[clearBank_i] = 1'b0;
    end
    if (writeEn_i) begin
      tag_d[writeBank_i] = writeTag_i;
      if (writeValid_i) begin
        valid_d[writeBank_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Lookup and line-fill sequencer: answers hits from the tag store and, on a miss,
// bursts a full line from external SRAM into the cache RAM before committing the tag.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int data_width         = DATA_WIDTH,
  parameter int address_depth_bits = ADDR_BITS,
  parameter int line_bits          = LINE_BITS,
  parameter int bank_bits          = BANK_BITS
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          req_valid_i,
  input  logic [address_depth_bits-1:0] req_address_i,
  output logic                          req_ready_o,
  output logic [address_depth_bits-1:0] rd_address_o,
  input  logic                          invalidate_i,
  output logic                          busy_o,
  output logic                          mem_req_o,
  output logic [address_depth_bits-1:0] mem_address_o,
  input  logic                          mem_ack_i,
  input  logic [data_width-1:0]         mem_data_i,
  output logic [bank_bits-1:0]          bank_i_select_o,
  output logic                          bank_enable_o,
  output logic [line_bits-1:0]          write_address_o,
  output logic [data_width-1:0]         write_data_o
);

  localparam int TagBits = address_depth_bits - line_bits - bank_bits;
  localparam int TagLsb  = line_bits + bank_bits;

  fillState_e                state_q, state_d;
  logic [line_bits-1:0]      beat_q, beat_d;
  logic [bank_bits-1:0]      fillBank_q, fillBank_d;
  logic [TagBits-1:0]        fillTag_q, fillTag_d;
  logic                      invPend_q, invPend_d;
  logic                      memReq_q, memReq_d;
  logic [address_depth_bits-1:0] memAddr_q, memAddr_d;
  logic [bank_bits-1:0]      bankSel_q, bankSel_d;
  logic                      bankEn_q, bankEn_d;
  logic [line_bits-1:0]      wrAddr_q, wrAddr_d;
  logic [data_width-1:0]     wrData_q, wrData_d;

  logic [bank_bits-1:0] reqBank;
  logic [TagBits-1:0]   reqTag;
  logic                 hit;
  logic                 ackFire;
  logic                 clearAll;
  logic                 clearBankEn;
  logic                 tagWrite;
  logic                 tagWriteValid;

  assign reqBank = req_address_i[TagLsb-1:line_bits];
  assign reqTag  = req_address_i[address_depth_bits-1:TagLsb];
  assign ackFire = mem_ack_i && memReq_q;

  cache_tag_store #(
    .bank_bits(bank_bits),
    .tag_bits (TagBits)
  ) u_tags (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .lookupBank_i (reqBank),
    .lookupTag_i  (reqTag),
    .hit_o        (hit),
    .clearBankEn_i(clearBankEn),
    .clearBank_i  (reqBank),
    .clearAll_i   (clearAll),
    .writeEn_i    (tagWrite),
    .writeBank_i  (fillBank_q),
    .writeTag_i   (fillTag_q),
    .writeValid_i (tagWriteValid)
  );

  assign req_ready_o     = (state_q == IDLE) && req_valid_i && hit;
  assign rd_address_o    = req_address_i;
  assign busy_o          = (state_q != IDLE);
  assign mem_req_o       = memReq_q;
  assign mem_address_o   = memAddr_q;
  assign bank_i_select_o = bankSel_q;
  assign bank_enable_o   = bankEn_q;
  assign write_address_o = wrAddr_q;
  assign write_data_o    = wrData_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    fillBank_d    = fillBank_q;
    fillTag_d     = fillTag_q;
    invPend_d     = invPend_q;
    memReq_d      = memReq_q;
    memAddr_d     = memAddr_q;
    bankSel_d     = bankSel_q;
    bankEn_d      = 1'b0;
    wrAddr_d      = wrAddr_q;
    wrData_d      = wrData_q;
    clearAll      = 1'b0;
    clearBankEn   = 1'b0;
    tagWrite      = 1'b0;
    tagWriteValid = 1'b0;

    unique case (state_q)
      IDLE: begin
        clearAll = invalidate_i;
        // Dropping the bank's valid bit on entry keeps a half-written line from ever hitting.
        if (req_valid_i && !hit) begin
          fillBank_d  = reqBank;
          fillTag_d   = reqTag;
          beat_d      = '0;
          invPend_d   = 1'b0;
          memReq_d    = 1'b1;
          memAddr_d   = {reqTag, reqBank, {line_bits{1'b0}}};
          clearBankEn = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (invalidate_i) begin
          invPend_d = 1'b1;
        end
        if (ackFire) begin
          wrData_d  = mem_data_i;
          wrAddr_d  = beat_q;
          bankSel_d = fillBank_q;
          bankEn_d  = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (beat_q == '1) begin
            memReq_d = 1'b0;
            state_d  = COMMIT;
          end else begin
            memAddr_d = memAddr_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        // An invalidate seen during the burst (or right now) wins over the fresh line.
        tagWrite      = 1'b1;
        tagWriteValid = !(invPend_q || invalidate_i);
        clearAll      = invPend_q || invalidate_i;
        invPend_d     = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      fillBank_q <= '0;
      fillTag_q  <= '0;
      invPend_q  <= 1'b0;
      memReq_q   <= 1'b0;
      memAddr_q  <= '0;
      bankSel_q  <= '0;
      bankEn_q   <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      fillBank_q <= fillBank_d;
      fillTag_q  <= fillTag_d;
      invPend_q  <= invPend_d;
      memReq_q   <= memReq_d;
      memAddr_q  <= memAddr_d;
      bankSel_q  <= bankSel_d;
      bankEn_q   <= bankEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
    end
  end

endmodule
